sram_line_scheduler: RTL and testbench

//  Sequencer for the NUM-line SRAM line buffer of the salt-and-pepper denoise path.

---
 rtl/sram_line_scheduler_if.sv | 32 +++
 rtl/sram_line_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_sram_line_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sram_line_scheduler_if.sv
// Signal bundle between the video timing source (master) and the line-buffer sequencer (slave).
interface sram_line_scheduler_if #(
    parameter int NUM = 5,
    parameter int AW  = 11
);
    localparam int NW = (NUM > 1) ? $clog2(NUM) : 1;

    logic            vsync;
    logic            hsync;
    logic [NUM-1:0]  bank_we;
    logic [NUM-1:0]  bank_re;
    logic [AW-1:0]   bank_addr;
    logic [NW-1:0]   oldest_bank;
    logic [AW-1:0]   col_cnt;
    logic [10:0]     row_cnt;
    logic            win_valid;
    logic [NUM-1:0]  win_row_vld;
    logic            frame_done;
    logic            err_line;

    modport master (
        output vsync, hsync,
        input  bank_we, bank_re, bank_addr, oldest_bank, col_cnt, row_cnt,
               win_valid, win_row_vld, frame_done, err_line
    );

    modport slave (
        input  vsync, hsync,
        output bank_we, bank_re, bank_addr, oldest_bank, col_cnt, row_cnt,
               win_valid, win_row_vld, frame_done, err_line
    );
endinterface

// File: rtl/sram_line_scheduler.sv
// Write-bank rotation, shared addressing and window-ready tracking for a NUM-line SRAM buffer.
// Optional border mode (define SRAM_SCHED_BORDER_EN): windows from row 0 with per-tap valid flags.
module sram_line_scheduler #(
    parameter int NUM        = 5,
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080,
    parameter int AW         = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_line_scheduler_if.slave bus
);
    localparam int NW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACTIVE,
        S_LEOL,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_vs_d;
    logic [NW-1:0]   r_wr_ptr;
    logic [NW-1:0]   r_oldest;
    logic [NW-1:0]   r_filled;
    logic [AW-1:0]   r_col;
    logic [10:0]     r_row;
    logic            r_last;
    logic            r_err;
    logic [NUM-1:0]  r_bank_we;
    logic [NUM-1:0]  r_bank_re;
    logic [AW-1:0]   r_bank_addr;
    logic            r_win_valid;
    logic            r_frame_done;

    logic            w_rise;
    logic            w_pix;
    logic            w_col_full;
    logic            w_win_ok;
    logic [NUM-1:0]  w_we_onehot;
    logic [NW-1:0]   w_ptr_next;
    logic [NW-1:0]   w_filled_next;

    function automatic logic [NW-1:0] f_next(input logic [NW-1:0] p);
        return (p == NW'(NUM - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_rise        = bus.vsync & ~r_vs_d;
    assign w_pix         = bus.vsync & bus.hsync & ((r_state == S_WAIT) | (r_state == S_ACTIVE));
    assign w_col_full    = (r_col == AW'(IMG_WIDTH));
    assign w_we_onehot   = {{(NUM-1){1'b0}}, 1'b1} << r_wr_ptr;
    assign w_ptr_next    = f_next(r_wr_ptr);
    assign w_filled_next = (r_filled == NW'(NUM - 1)) ? r_filled : r_filled + 1'b1;

`ifdef SRAM_SCHED_BORDER_EN
    // Tap k (0 = oldest) holds frame data once k >= NUM-1-filled.
    function automatic logic [NUM-1:0] f_row_mask(input logic [NW-1:0] filled);
        logic [NUM-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < NUM; k++) begin
            if (k + 32'(filled) >= 32'(NUM - 1)) m[k] = 1'b1;
        end
        return m;
    endfunction

    logic [NUM-1:0] r_win_row_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_row_vld <= '0;
        end else if (w_rise) begin
            r_win_row_vld <= f_row_mask('0);
        end else if (r_state == S_LEOL) begin
            r_win_row_vld <= f_row_mask(w_filled_next);
        end
    end

    assign bus.win_row_vld = r_win_row_vld;
    assign w_win_ok        = 1'b1;
`else
    assign bus.win_row_vld = '1;
    assign w_win_ok        = (r_filled == NW'(NUM - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vs_d       <= 1'b0;
            r_wr_ptr     <= '0;
            r_oldest     <= '0;
            r_filled     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_last       <= 1'b0;
            r_err        <= 1'b0;
            r_bank_we    <= '0;
            r_bank_re    <= '0;
            r_bank_addr  <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_vs_d       <= bus.vsync;
            r_bank_we    <= '0;
            r_bank_re    <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_rise) begin
                // A vsync rise in any state starts a fresh frame without frame_done.
                r_state  <= S_WAIT;
                r_wr_ptr <= '0;
                r_oldest <= f_next('0);
                r_filled <= '0;
                r_col    <= '0;
                r_row    <= '0;
                r_last   <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_WAIT: begin
                        if (!bus.vsync) begin
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                        end else if (bus.hsync) begin
                            r_state <= S_ACTIVE;
                        end
                    end
                    S_ACTIVE: begin
                        if (!bus.vsync || !bus.hsync) r_state <= S_LEOL;
                    end
                    S_LEOL: begin
                        r_wr_ptr <= w_ptr_next;
                        r_oldest <= f_next(w_ptr_next);
                        r_filled <= w_filled_next;
                        r_col    <= '0;
                        if (!w_col_full) r_err <= 1'b1;
                        // Row saturates on the last line; a line beyond it is an error.
                        if (r_row == 11'(IMG_HEIGHT - 1)) begin
                            if (r_last) r_err <= 1'b1;
                            r_last <= 1'b1;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                        if (!bus.vsync) begin
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase

                if (w_pix) begin
                    if (w_col_full) begin
                        r_err <= 1'b1;
                    end else begin
                        r_bank_we   <= w_we_onehot;
                        r_bank_re   <= ~w_we_onehot;
                        r_bank_addr <= r_col;
                        r_col       <= r_col + 1'b1;
                        r_win_valid <= w_win_ok;
                    end
                end
            end
        end
    end

    assign bus.bank_we     = r_bank_we;
    assign bus.bank_re     = r_bank_re;
    assign bus.bank_addr   = r_bank_addr;
    assign bus.oldest_bank = r_oldest;
    assign bus.col_cnt     = r_col;
    assign bus.row_cnt     = r_row;
    assign bus.win_valid   = r_win_valid;
    assign bus.frame_done  = r_frame_done;
    assign bus.err_line    = r_err;
endmodule

// File: tb/tb_sram_line_scheduler.sv
// Directed table-driven bench for sram_line_scheduler with NUM=5, W=8, H=6.
module tb_sram_line_scheduler;
    localparam int NUM = 5;
    localparam int W   = 8;
    localparam int H   = 6;
    localparam int AW  = 11;

`ifdef SRAM_SCHED_BORDER_EN
    localparam logic BORDER = 1'b1;
`else
    localparam logic BORDER = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    sram_line_scheduler_if #(.NUM(NUM), .AW(AW)) bus ();

    sram_line_scheduler #(
        .NUM       (NUM),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .AW        (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         npix;
        logic [4:0] we;
        logic [2:0] oldest;
        logic       wv_default;
        logic [4:0] rv_border;
        logic [10:0] row;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int npix, input logic [4:0] we, input logic [2:0] old,
                            input logic wv, input logic [4:0] rv, input logic [10:0] row);
        logic [4:0] re_exp;
        re_exp = ~we;
        for (int i = 0; i < npix; i++) begin
            bus.hsync = 1'b1;
            tick();
            if (i < W) begin
                chk("bank_we", bus.bank_we, we);
                chk("bank_re", bus.bank_re, re_exp);
                chk("bank_addr", bus.bank_addr, i);
                chk("win_valid", bus.win_valid, wv);
                chk("win_row_vld", bus.win_row_vld, rv);
                chk("row_cnt", bus.row_cnt, row);
                if (i == 0) chk("oldest_bank", bus.oldest_bank, old);
            end else begin
                chk("ovf_we", bus.bank_we, 0);
                chk("ovf_re", bus.bank_re, 0);
                chk("ovf_addr", bus.bank_addr, W - 1);
                chk("ovf_err", bus.err_line, 1);
            end
        end
        bus.hsync = 1'b0;
        tick();
        chk("eol_we", bus.bank_we, 0);
        tick();
        chk("eol_col", bus.col_cnt, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.vsync = 1'b0;
        bus.hsync = 1'b0;

        vecs[0] = '{8, 5'b00001, 3'd1, 1'b0, 5'b10000, 11'd0};
        vecs[1] = '{8, 5'b00010, 3'd2, 1'b0, 5'b11000, 11'd1};
        vecs[2] = '{8, 5'b00100, 3'd3, 1'b0, 5'b11100, 11'd2};
        vecs[3] = '{8, 5'b01000, 3'd4, 1'b0, 5'b11110, 11'd3};
        vecs[4] = '{8, 5'b10000, 3'd0, 1'b1, 5'b11111, 11'd4};
        vecs[5] = '{8, 5'b00001, 3'd1, 1'b1, 5'b11111, 11'd5};

        tick();
        tick();
        chk("rst_we", bus.bank_we, 0);
        chk("rst_re", bus.bank_re, 0);
        chk("rst_addr", bus.bank_addr, 0);
        chk("rst_oldest", bus.oldest_bank, 0);
        chk("rst_col", bus.col_cnt, 0);
        chk("rst_row", bus.row_cnt, 0);
        chk("rst_wv", bus.win_valid, 0);
        chk("rst_fd", bus.frame_done, 0);
        chk("rst_err", bus.err_line, 0);

        // Full frame of six 8-pixel lines.
        rst = 1'b0;
        tick();
        bus.vsync = 1'b1;
        tick();
        chk("start_oldest", bus.oldest_bank, 1);
        for (int v = 0; v < 6; v++) begin
            run_line(vecs[v].npix, vecs[v].we, vecs[v].oldest,
                     BORDER ? 1'b1 : vecs[v].wv_default,
                     BORDER ? vecs[v].rv_border : 5'b11111, vecs[v].row);
        end
        chk("sat_row", bus.row_cnt, H - 1);
        bus.vsync = 1'b0;
        tick();
        chk("frame_done_hi", bus.frame_done, 1);
        tick();
        chk("frame_done_lo", bus.frame_done, 0);
        chk("frame_err", bus.err_line, 0);

        // Overflow line (10 px) then short line (5 px) then a 1 px line.
        bus.vsync = 1'b1;
        tick();
        run_line(10, 5'b00001, 3'd1, BORDER, BORDER ? 5'b10000 : 5'b11111, 11'd0);
        chk("ovf_err_sticky", bus.err_line, 1);
        chk("ovf_oldest", bus.oldest_bank, 2);
        run_line(5, 5'b00010, 3'd2, 1'b0 | BORDER, BORDER ? 5'b11000 : 5'b11111, 11'd1);
        chk("short_err", bus.err_line, 1);
        run_line(1, 5'b00100, 3'd3, BORDER, BORDER ? 5'b11100 : 5'b11111, 11'd2);
        chk("short_err_sticky", bus.err_line, 1);
        bus.vsync = 1'b0;
        tick();
        tick();
        bus.vsync = 1'b1;
        tick();
        chk("err_clear_on_rise", bus.err_line, 0);

        // Reset mid-frame at row 2, col 3.
        run_line(8, 5'b00001, 3'd1, BORDER, BORDER ? 5'b10000 : 5'b11111, 11'd0);
        run_line(8, 5'b00010, 3'd2, BORDER, BORDER ? 5'b11000 : 5'b11111, 11'd1);
        bus.hsync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r2_addr", bus.bank_addr, i);
        end
        chk("r2_col", bus.col_cnt, 3);
        rst = 1'b1;
        tick();
        chk("mrst_we", bus.bank_we, 0);
        chk("mrst_re", bus.bank_re, 0);
        chk("mrst_addr", bus.bank_addr, 0);
        chk("mrst_oldest", bus.oldest_bank, 0);
        chk("mrst_col", bus.col_cnt, 0);
        chk("mrst_row", bus.row_cnt, 0);
        chk("mrst_wv", bus.win_valid, 0);
        chk("mrst_fd", bus.frame_done, 0);
        chk("mrst_err", bus.err_line, 0);
        rst       = 1'b0;
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_no_fd", bus.frame_done, 0);
        end

        // New frame, then vsync falls mid-line: LEOL first, then frame_done.
        bus.vsync = 1'b1;
        tick();
        bus.hsync = 1'b1;
        tick();
        chk("restart_we", bus.bank_we, 5'b00001);
        chk("restart_addr", bus.bank_addr, 0);
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        tick();
        chk("vfall_fd_wait", bus.frame_done, 0);
        tick();
        chk("vfall_fd", bus.frame_done, 1);
        chk("vfall_col", bus.col_cnt, 0);
        chk("vfall_oldest", bus.oldest_bank, 2);
        tick();
        chk("vfall_fd_lo", bus.frame_done, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
